// File: rtl/baccarat_datapath_if.sv
// Bundle between the baccarat statemachine (master) and the card-holding datapath (slave):
// dealt card, six load strobes, and the scores, card count, error flag and digits sent back.
interface baccarat_datapath_if;
  logic [3:0] new_card;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic [2:0] card_count;
  logic       load_error;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  // Strobes act as single-cycle commands sampled on the slow_clock edge; there is no
  // ready back-pressure, so a strobe is either accepted or flagged via load_error.
  modport master (
    output new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    input  pscore, dscore, pcard3, card_count, load_error,
           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    output pscore, dscore, pcard3, card_count, load_error,
           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/baccarat_datapath.sv
// Six write-once card registers for one baccarat hand, with combinational mod-10 scores,
// a per-hand card count, an illegal-load flag and active-low 7-segment digits.
module baccarat_datapath #(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic          slow_clock,
  input  logic          resetb,
  baccarat_datapath_if.slave bus
);

  // Index 0..2 = player cards 1..3, index 3..5 = dealer cards 1..3.
  logic [3:0] card_q [6];
  logic [2:0] count_q;
  logic       error_q;

  logic [5:0] strobe;
  logic       any_strobe;
  logic       multi_strobe;
  logic       bad_card;
  logic       illegal;
  logic       legal;
  logic [2:0] target;
  logic [3:0] target_val;

  assign strobe = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                   bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  always_comb begin
    target = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (strobe[i]) target = 3'(i);
    end
  end

  assign target_val   = card_q[target];
  assign any_strobe   = (strobe != 6'd0);
  assign multi_strobe = ((strobe & (strobe - 6'd1)) != 6'd0);
  assign bad_card     = (bus.new_card == 4'd0) || (bus.new_card > 4'd13);
  assign illegal      = any_strobe && (multi_strobe || (target_val != 4'd0) || bad_card);
  assign legal        = any_strobe && !illegal;

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) card_q[i] <= 4'd0;
      count_q <= 3'd0;
    end else if (legal) begin
      card_q[target] <= bus.new_card;
      if (count_q != 3'd6) count_q <= count_q + 3'd1;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      error_q <= 1'b0;
    end else if (illegal) begin
      error_q <= 1'b1;
    end else if (!ERR_STICKY) begin
      error_q <= 1'b0;
    end
  end

  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

  // Max sum is 27, so two conditional subtractions replace a divider.
  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  // Segment order {g,f,e,d,c,b,a}, low = lit.
  function automatic logic [6:0] seg7(input logic [3:0] c);
    logic [6:0] seg;
    case (c)
      4'd1:    seg = 7'b0001000;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b1000000;
      4'd11:   seg = 7'b1100001;
      4'd12:   seg = 7'b0011000;
      4'd13:   seg = 7'b0001001;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign bus.pscore     = hand_score(card_q[0], card_q[1], card_q[2]);
  assign bus.dscore     = hand_score(card_q[3], card_q[4], card_q[5]);
  assign bus.pcard3     = card_q[2];
  assign bus.card_count = count_q;
  assign bus.load_error = error_q;
  assign bus.HEX0       = seg7(card_q[0]);
  assign bus.HEX1       = seg7(card_q[1]);
  assign bus.HEX2       = seg7(card_q[2]);
  assign bus.HEX3       = seg7(card_q[3]);
  assign bus.HEX4       = seg7(card_q[4]);
  assign bus.HEX5       = seg7(card_q[5]);

endmodule

// File: tb/tb_baccarat_datapath.sv
// Directed bench for baccarat_datapath: a sticky-error and a pulse-error instance
// receive identical stimulus and are checked against hand-computed values.
module tb_baccarat_datapath;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;

  // Strobe bit order: [0]=p1 [1]=p2 [2]=p3 [3]=d1 [4]=d2 [5]=d3
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_P1   = 6'b000001;
  localparam logic [5:0] S_P2   = 6'b000010;
  localparam logic [5:0] S_P3   = 6'b000100;
  localparam logic [5:0] S_D1   = 6'b001000;
  localparam logic [5:0] S_D2   = 6'b010000;
  localparam logic [5:0] S_D3   = 6'b100000;

  logic slow_clock;
  logic resetb;
  int   vectors;
  int   miscompares;

  baccarat_datapath_if bus_s ();
  baccarat_datapath_if bus_p ();

  baccarat_datapath #(.ERR_STICKY(1'b1)) dut_sticky (
    .slow_clock(slow_clock), .resetb(resetb), .bus(bus_s.slave)
  );
  baccarat_datapath #(.ERR_STICKY(1'b0)) dut_pulse (
    .slow_clock(slow_clock), .resetb(resetb), .bus(bus_p.slave)
  );

  // Clock / reset
  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // Driver: set inputs on the falling edge, apply one rising edge, release strobes #1 later.
  task automatic apply(input logic [3:0] card, input logic [5:0] strb, input logic rst_n);
    @(negedge slow_clock);
    resetb = rst_n;
    bus_s.new_card = card;  bus_p.new_card = card;
    {bus_s.load_dcard3, bus_s.load_dcard2, bus_s.load_dcard1,
     bus_s.load_pcard3, bus_s.load_pcard2, bus_s.load_pcard1} = strb;
    {bus_p.load_dcard3, bus_p.load_dcard2, bus_p.load_dcard1,
     bus_p.load_pcard3, bus_p.load_pcard2, bus_p.load_pcard1} = strb;
    @(posedge slow_clock);
    #1;
    resetb = 1'b1;
    bus_s.new_card = 4'd0;  bus_p.new_card = 4'd0;
    {bus_s.load_dcard3, bus_s.load_dcard2, bus_s.load_dcard1,
     bus_s.load_pcard3, bus_s.load_pcard2, bus_s.load_pcard1} = S_NONE;
    {bus_p.load_dcard3, bus_p.load_dcard2, bus_p.load_dcard1,
     bus_p.load_pcard3, bus_p.load_pcard2, bus_p.load_pcard1} = S_NONE;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, " pscore"},  8'(bus_s.pscore),     8'd0);
    check({tag, " dscore"},  8'(bus_s.dscore),     8'd0);
    check({tag, " pcard3"},  8'(bus_s.pcard3),     8'd0);
    check({tag, " count"},   8'(bus_s.card_count), 8'd0);
    check({tag, " err_s"},   8'(bus_s.load_error), 8'd0);
    check({tag, " err_p"},   8'(bus_p.load_error), 8'd0);
    check({tag, " hex0"},    8'(bus_s.HEX0), 8'(SEG_BLANK));
    check({tag, " hex1"},    8'(bus_s.HEX1), 8'(SEG_BLANK));
    check({tag, " hex2"},    8'(bus_s.HEX2), 8'(SEG_BLANK));
    check({tag, " hex3"},    8'(bus_s.HEX3), 8'(SEG_BLANK));
    check({tag, " hex4"},    8'(bus_s.HEX4), 8'(SEG_BLANK));
    check({tag, " hex5"},    8'(bus_s.HEX5), 8'(SEG_BLANK));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetb = 1'b1;
    bus_s.new_card = 4'd0;  bus_p.new_card = 4'd0;
    {bus_s.load_dcard3, bus_s.load_dcard2, bus_s.load_dcard1,
     bus_s.load_pcard3, bus_s.load_pcard2, bus_s.load_pcard1} = S_NONE;
    {bus_p.load_dcard3, bus_p.load_dcard2, bus_p.load_dcard1,
     bus_p.load_pcard3, bus_p.load_pcard2, bus_p.load_pcard1} = S_NONE;

    // Reset held for two edges
    apply(4'd0, S_NONE, 1'b0);
    apply(4'd0, S_NONE, 1'b0);
    check_all_clear("reset");

    // Two-card deal P1=7, D1=K, P2=A, D2=5
    apply(4'd7, S_P1, 1'b1);
    check("p1 pscore", 8'(bus_s.pscore), 8'd7);
    check("p1 hex0",   8'(bus_s.HEX0),   8'(SEG_7));
    apply(4'd13, S_D1, 1'b1);
    check("d1 dscore", 8'(bus_s.dscore), 8'd0);
    check("d1 hex3",   8'(bus_s.HEX3),   8'(SEG_K));
    apply(4'd1, S_P2, 1'b1);
    check("p2 hex1",   8'(bus_s.HEX1),   8'(SEG_A));
    apply(4'd5, S_D2, 1'b1);
    check("deal pscore", 8'(bus_s.pscore),     8'd8);
    check("deal dscore", 8'(bus_s.dscore),     8'd5);
    check("deal count",  8'(bus_s.card_count), 8'd4);
    check("deal err_s",  8'(bus_s.load_error), 8'd0);
    check("deal err_p",  8'(bus_p.load_error), 8'd0);
    check("deal hex4",   8'(bus_s.HEX4),       8'(SEG_5));
    check("deal hex2",   8'(bus_s.HEX2),       8'(SEG_BLANK));
    check("deal pcard3", 8'(bus_s.pcard3),     8'd0);

    // Overwrite attempt on pcard1
    apply(4'd3, S_P1, 1'b1);
    check("ovw hex0",   8'(bus_s.HEX0),       8'(SEG_7));
    check("ovw pscore", 8'(bus_s.pscore),     8'd8);
    check("ovw count",  8'(bus_s.card_count), 8'd4);
    check("ovw err_s",  8'(bus_s.load_error), 8'd1);
    check("ovw err_p",  8'(bus_p.load_error), 8'd1);
    apply(4'd0, S_NONE, 1'b1);
    check("ovw+1 err_s", 8'(bus_s.load_error), 8'd1);
    check("ovw+1 err_p", 8'(bus_p.load_error), 8'd0);

    // Third cards P3=9, D3=Q
    apply(4'd9, S_P3, 1'b1);
    check("p3 pscore", 8'(bus_s.pscore), 8'd7);
    check("p3 pcard3", 8'(bus_s.pcard3), 8'd9);
    check("p3 hex2",   8'(bus_s.HEX2),   8'(SEG_9));
    apply(4'd12, S_D3, 1'b1);
    check("d3 dscore", 8'(bus_s.dscore),     8'd5);
    check("d3 hex5",   8'(bus_s.HEX5),       8'(SEG_Q));
    check("d3 count",  8'(bus_s.card_count), 8'd6);
    check("d3 err_p",  8'(bus_p.load_error), 8'd0);

    // Full hand: any further load is an overwrite, count stays 6
    apply(4'd4, S_D2, 1'b1);
    check("full count", 8'(bus_s.card_count), 8'd6);
    check("full err_p", 8'(bus_p.load_error), 8'd1);
    check("full hex4",  8'(bus_s.HEX4),       8'(SEG_5));

    // New hand: double strobe and out-of-range cards on empty registers
    apply(4'd0, S_NONE, 1'b0);
    check_all_clear("reset2");
    apply(4'd4, S_P1 | S_D1, 1'b1);
    check("dbl hex0",  8'(bus_s.HEX0),       8'(SEG_BLANK));
    check("dbl hex3",  8'(bus_s.HEX3),       8'(SEG_BLANK));
    check("dbl count", 8'(bus_s.card_count), 8'd0);
    check("dbl err_s", 8'(bus_s.load_error), 8'd1);
    check("dbl err_p", 8'(bus_p.load_error), 8'd1);
    apply(4'd0, S_NONE, 1'b1);
    check("dbl+1 err_p", 8'(bus_p.load_error), 8'd0);
    check("dbl+1 err_s", 8'(bus_s.load_error), 8'd1);
    apply(4'd14, S_P1, 1'b1);
    check("c14 hex0",  8'(bus_s.HEX0),       8'(SEG_BLANK));
    check("c14 count", 8'(bus_s.card_count), 8'd0);
    check("c14 err_p", 8'(bus_p.load_error), 8'd1);
    apply(4'd0, S_NONE, 1'b1);
    check("c14+1 err_p", 8'(bus_p.load_error), 8'd0);
    apply(4'd0, S_D1, 1'b1);
    check("c0 hex3",  8'(bus_s.HEX3),       8'(SEG_BLANK));
    check("c0 err_p", 8'(bus_p.load_error), 8'd1);
    apply(4'd15, S_P2, 1'b1);
    check("c15 hex1",  8'(bus_s.HEX1),       8'(SEG_BLANK));
    check("c15 err_p", 8'(bus_p.load_error), 8'd1);
    // A legal ten after the errors: pulse flag drops on this same edge
    apply(4'd10, S_D1, 1'b1);
    check("ten hex3",   8'(bus_s.HEX3),       8'(SEG_0));
    check("ten dscore", 8'(bus_s.dscore),     8'd0);
    check("ten count",  8'(bus_s.card_count), 8'd1);
    check("ten err_p",  8'(bus_p.load_error), 8'd0);
    check("ten err_s",  8'(bus_s.load_error), 8'd1);

    // Mid-hand reset with a load strobe on the same edge
    apply(4'd0, S_NONE, 1'b0);
    apply(4'd2, S_P1, 1'b1);
    apply(4'd3, S_D1, 1'b1);
    apply(4'd4, S_P2, 1'b1);
    check("mid pscore", 8'(bus_s.pscore),     8'd6);
    check("mid dscore", 8'(bus_s.dscore),     8'd3);
    check("mid count",  8'(bus_s.card_count), 8'd3);
    check("mid hex0",   8'(bus_s.HEX0),       8'(SEG_2));
    check("mid hex1",   8'(bus_s.HEX1),       8'(SEG_4));
    check("mid hex3",   8'(bus_s.HEX3),       8'(SEG_3));
    apply(4'd6, S_D2, 1'b0);
    check_all_clear("rst+load");
    apply(4'd0, S_NONE, 1'b1);
    check("post dscore", 8'(bus_s.dscore), 8'd0);
    apply(4'd6, S_D2, 1'b1);
    check("post d2 count",  8'(bus_s.card_count), 8'd1);
    check("post d2 dscore", 8'(bus_s.dscore),     8'd6);
    check("post d2 hex4",   8'(bus_s.HEX4),       8'(SEG_6));
    check("post d2 err_s",  8'(bus_s.load_error), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
